// File: rtl/dec_pkg.sv
// Shared types and width helpers for the multichannel ADPCM code unpacker.
// Bit order is selected by DEC_UNPACK_MSB_FIRST_EN (LSB-first when undefined).
package dec_pkg;

  typedef enum logic [1:0] {
    RATE_2B = 2'b00,
    RATE_3B = 2'b01,
    RATE_4B = 2'b10,
    RATE_5B = 2'b11
  } rate_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  localparam logic [1:0] RATE_RESET = RATE_4B;

  function automatic int acc_w(input int word_w);
    return word_w + 4;
  endfunction

  function automatic int cnt_w(input int word_w);
    return $clog2(word_w + 5);
  endfunction

  function automatic logic [2:0] rate_k(input logic [1:0] r);
    return {1'b0, r} + 3'd2;
  endfunction

endpackage

// File: rtl/dec_chan_acc.sv
// Per-channel accumulator, bit count and rate register file.
// One append/shift write port, one flush port, one combinational read port.
module dec_chan_acc
  import dec_pkg::*;
#(
  parameter int NCH = 4,
  parameter int WORD_W = 8,
  localparam int CHW = $clog2(NCH),
  localparam int ACC_W = acc_w(WORD_W),
  localparam int CNT_W = cnt_w(WORD_W)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_en,
  input  logic [CHW-1:0]        i_wr_ch,
  input  logic [ACC_W-1:0]      i_wr_acc,
  input  logic [CNT_W-1:0]      i_wr_cnt,
  input  logic [NCH-1:0]        i_flush_mask,
  input  logic [NCH-1:0][1:0]   i_flush_rate,
  input  logic [CHW-1:0]        i_rd_ch,
  output logic [ACC_W-1:0]      o_rd_acc,
  output logic [CNT_W-1:0]      o_rd_cnt,
  output logic [1:0]            o_rd_rate
);

  logic [ACC_W-1:0] r_acc  [NCH];
  logic [CNT_W-1:0] r_cnt  [NCH];
  logic [1:0]       r_rate [NCH];

  // A same-cycle append overrides the flush of acc/cnt; rate comes from flush
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        r_acc[i]  <= '0;
        r_cnt[i]  <= '0;
        r_rate[i] <= RATE_RESET;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (i_flush_mask[i]) begin
          r_acc[i]  <= '0;
          r_cnt[i]  <= '0;
          r_rate[i] <= i_flush_rate[i];
        end
        if (i_wr_en && (i_wr_ch == CHW'(i))) begin
          r_acc[i] <= i_wr_acc;
          r_cnt[i] <= i_wr_cnt;
        end
      end
    end
  end

  assign o_rd_acc  = r_acc[i_rd_ch];
  assign o_rd_cnt  = r_cnt[i_rd_ch];
  assign o_rd_rate = r_rate[i_rd_ch];

endmodule

// File: rtl/dec_code_unpack.sv
// Multichannel ADPCM code unpacker: splits tagged code words into 2..5-bit codes.
// Define DEC_UNPACK_MSB_FIRST_EN for MSB-first bit order.
module dec_code_unpack
  import dec_pkg::*;
#(
  parameter int NCH = 4,
  parameter int WORD_W = 8,
  parameter int NCHAINS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [$clog2(NCH)-1:0]  in_ch,
  input  logic [WORD_W-1:0]       in_data,
  input  logic                    rate_we,
  input  logic [$clog2(NCH)-1:0]  rate_ch,
  input  logic [1:0]              rate_val,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4:0]              out_code,
  output logic [$clog2(NCH)-1:0]  out_ch,
  output logic [1:0]              out_rate,
  input  logic [NCHAINS-1:0]      scan_in,
  input  logic                    scan_enable,
  input  logic                    test_mode,
  output logic [NCHAINS-1:0]      scan_out
);

  localparam int CHW = $clog2(NCH);
  localparam int ACC_W = acc_w(WORD_W);
  localparam int CNT_W = cnt_w(WORD_W);

  state_e           r_state;
  state_e           w_state_nx;
  logic             r_out_valid;
  logic [4:0]       r_out_code;
  logic [CHW-1:0]   r_out_ch;
  logic [1:0]       r_out_rate;
  logic [CHW-1:0]   r_ch;
  logic             r_pend_v;
  logic [1:0]       r_pend_rate;

  logic             w_idle;
  logic             w_accept;
  logic             w_hs;
  logic             w_rw_live;
  logic             w_rw_act;
  logic             w_rw_hit;
  logic [CHW-1:0]   w_rd_ch;
  logic [ACC_W-1:0] w_rd_acc;
  logic [CNT_W-1:0] w_rd_cnt;
  logic [1:0]       w_rd_rate;
  logic [ACC_W-1:0] w_base_acc;
  logic [CNT_W-1:0] w_base_cnt;
  logic [ACC_W-1:0] w_app_acc;
  logic [CNT_W-1:0] w_app_cnt;
  logic [ACC_W-1:0] w_src_acc;
  logic [CNT_W-1:0] w_src_cnt;
  logic [1:0]       w_src_rate;
  logic [2:0]       w_k;
  logic [CNT_W-1:0] w_kc;
  logic             w_have;
  logic [CNT_W-1:0] w_nx_cnt;
  logic [ACC_W-1:0] w_nx_acc;
  logic [4:0]       w_code;
  logic             w_load;
  logic             w_exit;
  logic             w_wr_en;
  logic             w_pend_v_eff;
  logic [1:0]       w_pend_rate_eff;
  logic [NCH-1:0]       w_flush_mask;
  logic [NCH-1:0][1:0]  w_flush_rate;
  logic             w_unused_scan;

  assign w_unused_scan = ^{scan_in, scan_enable};
  assign scan_out = '0;

  assign w_idle    = (r_state == ST_IDLE);
  assign in_ready  = reset & ~test_mode & w_idle;
  assign w_accept  = in_valid & in_ready;
  assign w_hs      = r_out_valid & out_ready & ~test_mode;
  assign w_rw_live = rate_we & ~test_mode;
  assign w_rw_act  = w_rw_live & ~w_idle & (rate_ch == r_ch);
  assign w_rw_hit  = w_rw_live & w_accept & (rate_ch == in_ch);

  assign w_rd_ch = w_idle ? in_ch : r_ch;

  dec_chan_acc #(
    .NCH    (NCH),
    .WORD_W (WORD_W)
  ) u_acc (
    .clk          (clk),
    .reset        (reset),
    .i_wr_en      (w_wr_en),
    .i_wr_ch      (w_rd_ch),
    .i_wr_acc     (w_nx_acc),
    .i_wr_cnt     (w_nx_cnt),
    .i_flush_mask (w_flush_mask),
    .i_flush_rate (w_flush_rate),
    .i_rd_ch      (w_rd_ch),
    .o_rd_acc     (w_rd_acc),
    .o_rd_cnt     (w_rd_cnt),
    .o_rd_rate    (w_rd_rate)
  );

  // Same-cycle rate write to the incoming channel: append onto a flushed state
  assign w_base_acc = w_rw_hit ? '0 : w_rd_acc;
  assign w_base_cnt = w_rw_hit ? '0 : w_rd_cnt;

`ifdef DEC_UNPACK_MSB_FIRST_EN
  assign w_app_acc = (w_base_acc << WORD_W) | ACC_W'(in_data);
`else
  assign w_app_acc = w_base_acc | (ACC_W'(in_data) << w_base_cnt);
`endif
  assign w_app_cnt = w_base_cnt + CNT_W'(WORD_W);

  assign w_src_acc  = w_idle ? w_app_acc : w_rd_acc;
  assign w_src_cnt  = w_idle ? w_app_cnt : w_rd_cnt;
  assign w_src_rate = w_rw_hit ? rate_val : w_rd_rate;

  assign w_k      = rate_k(w_src_rate);
  assign w_kc     = CNT_W'(w_k);
  assign w_have   = (w_src_cnt >= w_kc);
  assign w_nx_cnt = w_src_cnt - w_kc;

`ifdef DEC_UNPACK_MSB_FIRST_EN
  assign w_code   = 5'((w_src_acc >> w_nx_cnt) & ~({ACC_W{1'b1}} << w_k));
  assign w_nx_acc = w_src_acc & ~({ACC_W{1'b1}} << w_nx_cnt);
`else
  assign w_code   = 5'(w_src_acc & ~({ACC_W{1'b1}} << w_k));
  assign w_nx_acc = w_src_acc >> w_k;
`endif

  assign w_load  = w_accept | (~w_idle & w_hs & w_have);
  assign w_exit  = ~w_idle & w_hs & ~w_have;
  assign w_wr_en = w_load;

  assign w_pend_v_eff    = r_pend_v | w_rw_act;
  assign w_pend_rate_eff = w_rw_act ? rate_val : r_pend_rate;

  always_comb begin
    w_flush_mask = '0;
    w_flush_rate = '0;
    if (w_rw_live && !w_rw_act) begin
      w_flush_mask[rate_ch] = 1'b1;
      w_flush_rate[rate_ch] = rate_val;
    end
    if (w_exit && w_pend_v_eff) begin
      w_flush_mask[r_ch] = 1'b1;
      w_flush_rate[r_ch] = w_pend_rate_eff;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_state_nx = ST_EMIT;
      ST_EMIT: if (w_exit) w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_code  <= '0;
      r_out_ch    <= '0;
      r_out_rate  <= RATE_RESET;
      r_ch        <= '0;
      r_pend_v    <= 1'b0;
      r_pend_rate <= RATE_RESET;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_code  <= w_code;
        r_out_ch    <= w_rd_ch;
        r_out_rate  <= w_src_rate;
      end else if (w_exit) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) r_ch <= in_ch;
      if (w_exit) begin
        r_pend_v <= 1'b0;
      end else if (w_rw_act) begin
        r_pend_v    <= 1'b1;
        r_pend_rate <= rate_val;
      end
    end
  end

  assign out_valid = r_out_valid & ~test_mode;
  assign out_code  = r_out_code;
  assign out_ch    = r_out_ch;
  assign out_rate  = r_out_rate;

endmodule

// File: doc/dec_code_unpack.md
# dec_code_unpack

Parametrised multichannel ADPCM code unpacker in front of the `dec` datapath. It accepts packed code bytes tagged with a channel number and keeps a bit accumulator per channel. It splits each channel's bit stream into 2/3/4/5-bit codes (16/24/32/40 kbit/s modes) and hands them to the decoder one per cycle over a valid/ready handshake. It generalises the fixed single-channel, five-chain `dec` top to NCH channels, per-channel rate mode and NCHAINS scan chains.

## Interface
- NCH, 4, number of channels (≥2, power of two)
- WORD_W, 8, input word width in bits (≥5)
- NCHAINS, 5, number of scan chains
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (sampled on rising clk)
- in_valid  in  1  input word present
- in_ready  out  1  input word accepted when in_valid & in_ready
- in_ch  in  clog2(NCH)  input channel
- in_data  in  WORD_W  packed code bits
- rate_we  in  1  rate write strobe (always accepted)
- rate_ch  in  clog2(NCH)  rate write channel
- rate_val  in  2  00=2b, 01=3b, 10=4b, 11=5b
- out_valid  out  1  code present
- out_ready  in  1  code consumed when out_valid & out_ready
- out_code  out  5  code, right-aligned, zero-extended
- out_ch  out  clog2(NCH)  channel of out_code
- out_rate  out  2  rate_val in force when the code was extracted
- scan_in  in  NCHAINS  scan chain inputs
- scan_enable  in  1  scan shift enable
- test_mode  in  1  DFT test mode
- scan_out  out  NCHAINS  scan chain outputs; tied 0 in RTL, stitched by DFT insertion

## Operation
- Per-channel state: acc[WORD_W+4 bits], cnt[clog2(WORD_W+5) bits], rate[2].
- k = rate+2. Maximum residue is k-1 ≤ 4, so acc never overflows.
- FSM IDLE/EMIT.
- IDLE:
  - in_ready=1.
  - On accept: acc[c] |= in_data << cnt[c]; cnt[c] += WORD_W; active channel := c; go to EMIT.
- EMIT:
  - in_ready=0.
  - If cnt[c] ≥ k: present acc[c][k-1:0] on out_code.
  - On handshake: acc[c] >>= k, cnt[c] -= k; the next code is presented the following cycle.
  - When cnt[c] < k: return to IDLE; residue bits are kept.
- Outputs are registered and held stable while out_valid & !out_ready.
- Rate write to a channel that is not active in EMIT: next cycle rate[ch]=rate_val, cnt[ch]=0, acc[ch]=0.
- Rate write to the active channel during EMIT: stored in a one-entry pending register, applied (with flush) in the cycle EMIT→IDLE. A later write replaces the pending one.
- Rate write and input accept to the same channel in the same IDLE cycle: flush applied first, then the word is appended to the empty accumulator at the new rate.
- Reset values:
  - in_ready=0 while reset=0, then 1 (IDLE).
  - out_valid=0, out_code=0, out_ch=0, out_rate=2'b10.
  - All cnt=0, acc=0, rate=2'b10, pending cleared, scan_out=0.
- Reset asserted mid-EMIT: the presented code is discarded; all state is as after reset the next cycle.
- test_mode=1: in_ready forced 0 and out_valid forced 0. Internal state holds except under scan shift.

## Timing
- Word accepted at edge t → first out_valid at edge t+1.
- One code per cycle with out_ready held 1.
- Codes from one word: ⌊(cnt+WORD_W)/k⌋, at most 4 with WORD_W=8.
- in_ready rises the cycle after the last code's handshake.
- Sustained throughput is therefore one word per (codes+1) cycles.
- Rate write latency is 1 cycle, or the end of EMIT if pending.

## Configuration
- DEC_UNPACK_MSB_FIRST_EN defined: bit order is MSB-first.
  - The word is appended below the residue: acc = (acc << WORD_W) | in_data.
  - The code is taken from the top cnt bits.
- Macro absent: LSB-first, as described in Operation.

## Structure
- Package dec_pkg holds:
  - rate enum (RATE_2B..RATE_5B)
  - RATE_RESET=2'b10
  - the k-from-rate function
  - the ACC_W and CNT_W width functions
- One sub-module, dec_chan_acc: the per-channel accumulator/count/rate register file, with one append/shift port and one flush port. Top holds the FSM, pending register and output register.

## Test plan
- Rate 4b, ch0, in_data=0xA5 → codes 0x5, 0xA on ch0 in consecutive cycles. With DEC_UNPACK_MSB_FIRST_EN → 0xA, 0x5.
- Rate 2b, ch2, 0xE4 → 0x0, 0x1, 0x2, 0x3; cnt[2]=0 afterwards.
- Rate 5b, ch1, 0xFF then 0x03:
  - first word → 0x1F, residue 3 bits
  - second word → 0x1F, 0x00, residue 1 bit
- Hold out_ready=0 for 3 cycles during EMIT → out_code/out_ch stable, in_ready=0, no code lost or duplicated.
- Interleave ch0 and ch3 words at different rates → each channel's residue is preserved independently.
- Rate write to the active channel mid-EMIT → current word's codes finish at the old rate, then that channel is flushed with the new rate. Reset pulse mid-EMIT → out_valid=0 next cycle, all cnt=0.
